// File: rtl/nrzi_tx_pkg.sv
// Shared types and constants for the NRZI serial transmitter.
package nrzi_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_LOW,
    S_EOP_IDLE
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam int unsigned EOP_LOW_BITS = 2;
  localparam logic        LINE_IDLE    = 1'b1;

  // NRZI: a 0 toggles the line, a 1 holds it.
  function automatic logic nrzi_next(input logic prev, input logic data_bit);
    return data_bit ? prev : ~prev;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: strobes on the last clk cycle of every line bit.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_strobe
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo counter, held at zero whenever the transmitter is idle.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_strobe = enable && (cnt == LAST);

endmodule

// File: rtl/nrzi_serial_tx.sv
// NRZI serial transmitter: SYNC prefix, LSB-first bytes, bit stuffing, EOP.
module nrzi_serial_tx
  import nrzi_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
  localparam logic [2:0] EOP_LAST_IDX = 3'(EOP_LOW_BITS - 1);

  tx_state_t         state;
  logic              ret_sync;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              sh_last;
  logic [7:0]        hold_data;
  logic              hold_last;
  logic              hold_full;
  logic [ONES_W-1:0] ones;
  logic [ONES_W-1:0] ones_inc;
  logic              nrzi;
  logic              done_pend;

  logic bit_strobe;
  logic accept;
  logic cur_level;
  logic stuff_entry;
  logic byte_end;
  logic from_sync;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (tx_active),
    .bit_strobe(bit_strobe)
  );

  // Line level of the bit being timed, plus the bit-boundary decisions.
  always_comb begin
    accept   = tx_valid && tx_ready;
    ones_inc = ones + ONES_W'(1);
    case (state)
      S_SYNC, S_DATA: cur_level = nrzi_next(nrzi, shreg[0]);
      S_STUFF:        cur_level = nrzi_next(nrzi, 1'b0);
      S_EOP_LOW:      cur_level = 1'b0;
      default:        cur_level = LINE_IDLE;
    endcase
    stuff_entry = bit_strobe && (state == S_SYNC || state == S_DATA)
                  && shreg[0] && (ones_inc == ONES_MAX);
    // A stuff after bit 7 wraps bit_idx to 0, so the byte decision waits for it.
    byte_end = bit_strobe
               && (((state == S_SYNC || state == S_DATA) && bit_idx == 3'd7 && !stuff_entry)
                   || (state == S_STUFF && bit_idx == 3'd0));
    from_sync = (state == S_SYNC) || (state == S_STUFF && ret_sync);
  end

  // Packet FSM, holding register, shifter, ones counter and registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ret_sync    <= 1'b0;
      bit_idx     <= '0;
      shreg       <= '0;
      sh_last     <= 1'b0;
      hold_data   <= '0;
      hold_last   <= 1'b0;
      hold_full   <= 1'b0;
      ones        <= '0;
      nrzi        <= LINE_IDLE;
      serial_out  <= LINE_IDLE;
      tx_ready    <= 1'b1;
      tx_active   <= 1'b0;
      tx_done     <= 1'b0;
      done_pend   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      done_pend   <= 1'b0;
      tx_done     <= done_pend;
      serial_out  <= cur_level;

      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      // Assignments below take precedence over the accept path above.
      case (state)
        S_IDLE: begin
          ones <= '0;
          nrzi <= LINE_IDLE;
          if (accept || hold_full) begin
            state     <= S_SYNC;
            shreg     <= SYNC_BYTE;
            sh_last   <= 1'b0;
            bit_idx   <= '0;
            ret_sync  <= 1'b1;
            tx_active <= 1'b1;
          end
        end

        S_SYNC, S_DATA, S_STUFF: begin
          if (bit_strobe) begin
            nrzi <= cur_level;
            if (state == S_STUFF) begin
              ones <= '0;
            end else begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
              ones    <= (stuff_entry || !shreg[0]) ? '0 : ones_inc;
            end

            if (stuff_entry) begin
              state    <= S_STUFF;
              ret_sync <= (state == S_SYNC);
            end else if (byte_end) begin
              if (!from_sync && sh_last) begin
                state    <= S_EOP_LOW;
                bit_idx  <= '0;
                tx_ready <= 1'b0;
              end else if (hold_full) begin
                shreg     <= hold_data;
                sh_last   <= hold_last;
                hold_full <= 1'b0;
                tx_ready  <= !hold_last;
                bit_idx   <= '0;
                state     <= S_DATA;
              end else begin
                tx_underrun <= 1'b1;
                state       <= S_EOP_LOW;
                bit_idx     <= '0;
                tx_ready    <= 1'b0;
              end
            end else if (state == S_STUFF) begin
              state <= ret_sync ? S_SYNC : S_DATA;
            end
          end
        end

        S_EOP_LOW: begin
          if (bit_strobe) begin
            if (bit_idx == EOP_LAST_IDX) begin
              state <= S_EOP_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        S_EOP_IDLE: begin
          if (bit_strobe) begin
            state     <= S_IDLE;
            tx_active <= 1'b0;
            done_pend <= 1'b1;
            nrzi      <= LINE_IDLE;
            tx_ready  <= !hold_full;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_serial_tx.sv
// Directed self-checking bench for nrzi_serial_tx.
module tb_nrzi_serial_tx;

  localparam int C  = 8;
  localparam int SL = 6;

  // Hand-derived line levels per bit time, bit 0 leftmost (unused tail bits 0).
  localparam logic [0:19] LV00 = 20'b01010100_10101010_0010;
  localparam logic [0:19] LVFF = 20'b01010100_00000111_1001;
  localparam logic [0:19] LV12 = 20'b01010100_11011010_0010;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       serial_out;
  logic       tx_active;
  logic       tx_done;
  logic       tx_underrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nrzi_serial_tx #(
    .CLKS_PER_BIT(C),
    .STUFF_LEN   (SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_underrun(tx_underrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with tx_valid just raised; follows one packet cycle by cycle.
  task automatic watch(input string name, input logic [0:19] lv, input int nbits,
                       input int und_n, input bit rdy_mid);
    logic exp_line;
    logic exp_rdy;
    check({name, ".rdy0"}, int'(tx_ready), 1);
    for (int n = 1; n <= nbits * C + 4; n++) begin
      @(negedge clk);
      if (n == 1) tx_valid = 1'b0;
      exp_line = (n >= 2 && n <= nbits * C + 1) ? lv[(n - 2) / C] : 1'b1;
      exp_rdy  = (n >= nbits * C + 1) || (rdy_mid && n >= 8 * C + 1 && n <= 16 * C);
      check($sformatf("%s.line@%0d", name, n), int'(serial_out), int'(exp_line));
      check($sformatf("%s.done@%0d", name, n), int'(tx_done), int'(n == nbits * C + 2));
      check($sformatf("%s.active@%0d", name, n), int'(tx_active), int'(n <= nbits * C));
      check($sformatf("%s.underrun@%0d", name, n), int'(tx_underrun), int'(n == und_n));
      check($sformatf("%s.ready@%0d", name, n), int'(tx_ready), int'(exp_rdy));
    end
  endtask

  initial begin
    logic       smp [0:400];
    logic [7:0] bytes_in [3];
    logic [7:0] dec [3];
    logic       fire;
    logic       prev;
    logic       b;
    logic       und_seen;
    logic       line_bad;
    logic       done_seen;
    int         idx;
    int         done_m;
    int         acc_m [3];
    int         ones;
    int         pos;
    int         kend;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.line", int'(serial_out), 1);
    check("rst.ready", int'(tx_ready), 1);
    check("rst.active", int'(tx_active), 0);
    check("rst.done", int'(tx_done), 0);
    check("rst.underrun", int'(tx_underrun), 0);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle.line@%0d", i), int'(serial_out), 1);
      check($sformatf("idle.ready@%0d", i), int'(tx_ready), 1);
      check($sformatf("idle.active@%0d", i), int'(tx_active), 0);
    end

    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    watch("b00", LV00, 19, -1, 1'b0);

    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
    watch("bFF", LVFF, 20, -1, 1'b0);

    tx_valid = 1'b1; tx_data = 8'h12; tx_last = 1'b0;
    watch("b12", LV12, 19, 16 * C + 1, 1'b1);

    // Three back-to-back bytes with tx_valid held high.
    bytes_in[0] = 8'hA5; bytes_in[1] = 8'h3C; bytes_in[2] = 8'h7E;
    idx = 0; done_m = 0; und_seen = 1'b0;
    acc_m[0] = 0; acc_m[1] = 0; acc_m[2] = 0;
    for (int m = 0; m <= 400; m++) smp[m] = 1'b1;
    tx_valid = 1'b1; tx_data = bytes_in[0]; tx_last = 1'b0;
    for (int m = 1; m <= 40 * C; m++) begin
      fire = tx_valid && tx_ready;
      @(negedge clk);
      smp[m] = serial_out;
      und_seen = und_seen | tx_underrun;
      if (tx_done && done_m == 0) done_m = m;
      if (fire) begin
        check($sformatf("b3.rdy_drop%0d", idx), int'(tx_ready), 0);
        acc_m[idx] = m;
        idx++;
        if (idx < 3) begin
          tx_data = bytes_in[idx];
          tx_last = (idx == 2);
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
    end
    check("b3.accepts", idx, 3);
    check("b3.acc1", acc_m[1], 8 * C + 2);
    check("b3.acc2", acc_m[2], 16 * C + 2);
    check("b3.underrun", int'(und_seen), 0);
    check("b3.done_at", done_m, 36 * C + 2);

    // Reference decoder: mid-bit sampling, NRZI decode, destuff, drop SYNC.
    prev = 1'b1; ones = 0; pos = 0; kend = 0;
    dec[0] = 8'h00; dec[1] = 8'h00; dec[2] = 8'h00;
    for (int k = 0; k < 40; k++) begin
      b = (smp[2 + k * C + C / 2] == prev);
      prev = smp[2 + k * C + C / 2];
      if (ones == SL) begin
        check($sformatf("b3.stuff@%0d", k), int'(b), 0);
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        if (pos >= 8) dec[(pos - 8) / 8][(pos - 8) % 8] = b;
        pos++;
      end
      if (pos == 32) begin
        kend = k + 1;
        break;
      end
    end
    check("b3.line_bits", kend, 33);
    check("b3.byte0", int'(dec[0]), 'hA5);
    check("b3.byte1", int'(dec[1]), 'h3C);
    check("b3.byte2", int'(dec[2]), 'h7E);
    check("b3.eop0", int'(smp[2 + 33 * C + C / 2]), 0);
    check("b3.eop1", int'(smp[2 + 34 * C + C / 2]), 0);
    check("b3.eop2", int'(smp[2 + 35 * C + C / 2]), 1);

    // Reset in the middle of a data byte.
    repeat (4) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    for (int n = 1; n <= 12 * C; n++) begin
      @(negedge clk);
      if (n == 1) tx_valid = 1'b0;
    end
    check("mid.pre_line", int'(serial_out), 0);
    check("mid.pre_active", int'(tx_active), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid.line", int'(serial_out), 1);
    check("mid.ready", int'(tx_ready), 1);
    check("mid.active", int'(tx_active), 0);
    done_seen = 1'b0; line_bad = 1'b0;
    for (int n = 1; n <= 25 * C; n++) begin
      @(negedge clk);
      done_seen = done_seen | tx_done;
      line_bad  = line_bad | !serial_out;
    end
    check("mid.no_done", int'(done_seen), 0);
    check("mid.line_held", int'(line_bad), 0);

    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    watch("post", LV00, 19, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
